game_pixel_renderer: RTL
========================

Name: game_pixel_renderer

Overview:
- Pixel source directly upstream of VGA_controller; produces the 8-bit RGB byte for its i_RGB input.
- Takes the current pixel coordinate and active-video flag from the display timing, plus player buttons from the game controller.
- Renders background, screen border and a movable player sprite, in 3-3-2 RGB (R[7:5] G[4:2] B[1:0]).
- Sprite position updates once per frame, during blanking, to avoid tearing.

Parameters:
- H_ACTIVE, 640, visible columns.
- V_ACTIVE, 480, visible rows.
- SPRITE_W, 16, sprite width in pixels.
- SPRITE_H, 16, sprite height in pixels.
- STEP, 2, pixels moved per frame per pressed direction.
- BG_COLOR, 8'h03, background colour.
- BORDER_COLOR, 8'hFF, one-pixel screen border colour.
- SPRITE_COLOR, 8'hE0, sprite colour.

Ports:
- i_CLK  input  1  pixel clock.
- i_RESET  input  1  synchronous, active-low reset.
- i_COL  input  10  current pixel column.
- i_ROW  input  10  current pixel row.
- i_ACTIVE  input  1  high while (i_COL, i_ROW) is visible.
- i_FRAME_TICK  input  1  one-cycle pulse at start of vertical blanking.
- i_BTN_UP / i_BTN_DOWN / i_BTN_LEFT / i_BTN_RIGHT  input  1 each  asynchronous, active-high buttons.
- o_RGB  output  8  pixel colour to VGA_controller i_RGB.
- o_RGB_VALID  output  1  o_RGB corresponds to a visible pixel.

Behaviour:
- Reset: synchronous, active-low, sampled on the i_CLK rising edge.
  - Clears o_RGB=8'h00, o_RGB_VALID=0, all pipeline registers and synchronizers.
  - Sets r_X=(H_ACTIVE-SPRITE_W)/2=312 and r_Y=(V_ACTIVE-SPRITE_H)/2=232.
  - Reset has priority over i_FRAME_TICK.
  - Reset mid-frame: outputs are 0 from the next edge; rendering resumes with the first coordinate presented after release.
- Button input: each button passes through a 2-flop synchronizer. A press seen at the pins is visible to position logic after 2 cycles.
- Position update:
  - Occurs only on a cycle with i_FRAME_TICK=1; otherwise r_X/r_Y hold.
  - Per axis: exactly one of the two opposing buttons pressed → move STEP in that direction; both or neither pressed → no change.
  - Clamp to [0, H_ACTIVE-SPRITE_W] for X and [0, V_ACTIVE-SPRITE_H] for Y.
  - Left with r_X<STEP → r_X=0. Right with r_X+STEP>624 → r_X=624. Same rule for Y with max 464.
  - Arithmetic is 11-bit internally, so no wrap-around is possible.
- Pixel pipeline: 2-cycle latency. Coordinate at edge N produces o_RGB after edge N+2.
  - Stage 1 registers:
    - sprite_hit = (i_COL>=r_X) && (i_COL<r_X+SPRITE_W) && (i_ROW>=r_Y) && (i_ROW<r_Y+SPRITE_H).
    - border_hit = i_COL==0 || i_COL==H_ACTIVE-1 || i_ROW==0 || i_ROW==V_ACTIVE-1.
    - active.
  - Stage 2: if !active → o_RGB=8'h00. Otherwise priority sprite > border > background.
  - o_RGB_VALID = i_ACTIVE delayed 2 cycles.
- Sprite hit uses r_X/r_Y as registered at stage 1; an update on the tick cycle affects the following coordinates only.
- Inputs with i_ACTIVE=0 never produce non-zero colour, whatever the coordinate values.

Optional Feature:
- Macro: GRID_OVERLAY_EN.
- Defined: stage 1 also registers grid_hit = (i_COL[4:0]==0) || (i_ROW[4:0]==0). Stage 2 priority becomes sprite > border > grid > background, with grid colour 8'h49.
- Undefined: no grid logic is synthesized; output is identical to the base behaviour.

Decomposition:
- Shared package vga_pkg:
  - H_ACTIVE/V_ACTIVE defaults.
  - COORD_W=10.
  - Colour constants (BLACK, BG, BORDER, SPRITE, GRID).
  - 3-3-2 field positions.
- Sub-module sprite_pos_ctrl: button synchronizers plus the frame-tick position update and clamp. Outputs r_X/r_Y.
- Top level holds the 2-stage pixel pipeline.

Test Plan:
- Reset low 3 cycles, then release; no ticks → o_RGB=00, o_RGB_VALID=0 during reset; sprite at (312,232): coordinate (312,232) active → o_RGB=E0 two cycles later, (328,232) → 03.
- Active coordinate (0,100) → o_RGB=FF at +2 cycles; (639,479) → FF; same coordinates with i_ACTIVE=0 → 00 and o_RGB_VALID=0.
- Hold i_BTN_RIGHT, issue 3 frame ticks → r_X=318; sprite pixel (318,232) → E0, (317,232) → 03.
- Hold i_BTN_LEFT for 200 ticks → r_X clamps to 0, never wraps. Hold i_BTN_DOWN for 200 ticks → r_Y=464.
- Hold i_BTN_UP and i_BTN_DOWN together, then 5 ticks → r_Y unchanged at 232. Pulse reset coincident with a tick while right is held → r_X=312.
- Build with GRID_OVERLAY_EN: (64,100) → 49, (64,100) inside sprite → E0. Build without it: (64,100) → 03.

Source files
------------

// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Shared display constants for the VGA pixel path: raster size,
//               coordinate width, 3-3-2 colour fields and palette.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int COORD_W      = 10;
    localparam int POS_W        = 11;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    // 3-3-2 field positions within the RGB byte
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    localparam logic [7:0] BLACK  = 8'h00;
    localparam logic [7:0] BG     = 8'h03;
    localparam logic [7:0] BORDER = 8'hFF;
    localparam logic [7:0] SPRITE = 8'hE0;
    localparam logic [7:0] GRID   = 8'h49;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } btn_t;

    function automatic logic [7:0] pack_rgb(input logic [2:0] r,
                                            input logic [2:0] g,
                                            input logic [1:0] b);
        logic [7:0] v;
        v              = 8'h00;
        v[R_MSB:R_LSB] = r;
        v[G_MSB:G_LSB] = g;
        v[B_MSB:B_LSB] = b;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_pos_ctrl.sv
// ============================================================================
// Module      : sprite_pos_ctrl
// Description : Button synchronizers and once-per-frame sprite position update
//               with clamping to the visible area.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_pos_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int STEP     = 2
) (
    input  logic               i_CLK,
    input  logic               i_RESET,
    input  logic               i_FRAME_TICK,
    input  logic               i_BTN_UP,
    input  logic               i_BTN_DOWN,
    input  logic               i_BTN_LEFT,
    input  logic               i_BTN_RIGHT,
    output logic [COORD_W-1:0] o_X,
    output logic [COORD_W-1:0] o_Y
);

    localparam logic [COORD_W-1:0] C_X_MAX  = COORD_W'(H_ACTIVE - SPRITE_W);
    localparam logic [COORD_W-1:0] C_Y_MAX  = COORD_W'(V_ACTIVE - SPRITE_H);
    localparam logic [COORD_W-1:0] C_X_HOME = COORD_W'((H_ACTIVE - SPRITE_W) / 2);
    localparam logic [COORD_W-1:0] C_Y_HOME = COORD_W'((V_ACTIVE - SPRITE_H) / 2);
    localparam logic [COORD_W-1:0] C_STEP   = COORD_W'(STEP);

    btn_t               r_btn_meta;
    btn_t               r_btn_sync;
    logic [COORD_W-1:0] r_X;
    logic [COORD_W-1:0] r_Y;
    logic [COORD_W-1:0] w_x_nxt;
    logic [COORD_W-1:0] w_y_nxt;

    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            r_btn_meta <= '0;
            r_btn_sync <= '0;
        end else begin
            r_btn_meta <= '{up: i_BTN_UP, down: i_BTN_DOWN,
                            left: i_BTN_LEFT, right: i_BTN_RIGHT};
            r_btn_sync <= r_btn_meta;
        end
    end

    // Bounds are tested in 11 bits so the add never wraps before the compare;
    // the 10-bit result is only taken on the in-range branch.
    always_comb begin
        w_x_nxt = r_X;
        if (r_btn_sync.left && !r_btn_sync.right) begin
            w_x_nxt = (r_X < C_STEP) ? '0 : r_X - C_STEP;
        end else if (r_btn_sync.right && !r_btn_sync.left) begin
            w_x_nxt = (({1'b0, r_X} + POS_W'(STEP)) > {1'b0, C_X_MAX}) ? C_X_MAX : r_X + C_STEP;
        end
    end

    always_comb begin
        w_y_nxt = r_Y;
        if (r_btn_sync.up && !r_btn_sync.down) begin
            w_y_nxt = (r_Y < C_STEP) ? '0 : r_Y - C_STEP;
        end else if (r_btn_sync.down && !r_btn_sync.up) begin
            w_y_nxt = (({1'b0, r_Y} + POS_W'(STEP)) > {1'b0, C_Y_MAX}) ? C_Y_MAX : r_Y + C_STEP;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            r_X <= C_X_HOME;
            r_Y <= C_Y_HOME;
        end else if (i_FRAME_TICK) begin
            r_X <= w_x_nxt;
            r_Y <= w_y_nxt;
        end
    end

    assign o_X = r_X;
    assign o_Y = r_Y;

endmodule

`default_nettype wire

// File: rtl/game_pixel_renderer.sv
// ============================================================================
// Module      : game_pixel_renderer
// Description : Two-stage pixel pipeline drawing background, border and a
//               movable sprite in 3-3-2 RGB. Define GRID_OVERLAY_EN to add a
//               32-pixel grid overlay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_pixel_renderer
    import vga_pkg::*;
#(
    parameter int         H_ACTIVE     = H_ACTIVE_DEF,
    parameter int         V_ACTIVE     = V_ACTIVE_DEF,
    parameter int         SPRITE_W     = 16,
    parameter int         SPRITE_H     = 16,
    parameter int         STEP         = 2,
    parameter logic [7:0] BG_COLOR     = BG,
    parameter logic [7:0] BORDER_COLOR = BORDER,
    parameter logic [7:0] SPRITE_COLOR = SPRITE
) (
    input  logic               i_CLK,
    input  logic               i_RESET,
    input  logic [COORD_W-1:0] i_COL,
    input  logic [COORD_W-1:0] i_ROW,
    input  logic               i_ACTIVE,
    input  logic               i_FRAME_TICK,
    input  logic               i_BTN_UP,
    input  logic               i_BTN_DOWN,
    input  logic               i_BTN_LEFT,
    input  logic               i_BTN_RIGHT,
    output logic [7:0]         o_RGB,
    output logic               o_RGB_VALID
);

    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic               w_sprite_hit;
    logic               w_border_hit;
    logic [7:0]         w_rgb;
    logic               r_sprite_hit;
    logic               r_border_hit;
    logic               r_active;
    logic [7:0]         r_rgb;
    logic               r_rgb_valid;

    sprite_pos_ctrl #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .STEP     (STEP)
    ) u_pos (
        .i_CLK        (i_CLK),
        .i_RESET      (i_RESET),
        .i_FRAME_TICK (i_FRAME_TICK),
        .i_BTN_UP     (i_BTN_UP),
        .i_BTN_DOWN   (i_BTN_DOWN),
        .i_BTN_LEFT   (i_BTN_LEFT),
        .i_BTN_RIGHT  (i_BTN_RIGHT),
        .o_X          (w_x),
        .o_Y          (w_y)
    );

    assign w_sprite_hit = (i_COL >= w_x) && ({1'b0, i_COL} < ({1'b0, w_x} + POS_W'(SPRITE_W))) &&
                          (i_ROW >= w_y) && ({1'b0, i_ROW} < ({1'b0, w_y} + POS_W'(SPRITE_H)));
    assign w_border_hit = (i_COL == '0) || (i_COL == COORD_W'(H_ACTIVE - 1)) ||
                          (i_ROW == '0) || (i_ROW == COORD_W'(V_ACTIVE - 1));

    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            r_sprite_hit <= 1'b0;
            r_border_hit <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_sprite_hit <= w_sprite_hit;
            r_border_hit <= w_border_hit;
            r_active     <= i_ACTIVE;
        end
    end

`ifdef GRID_OVERLAY_EN
    logic r_grid_hit;

    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            r_grid_hit <= 1'b0;
        end else begin
            r_grid_hit <= (i_COL[4:0] == 5'd0) || (i_ROW[4:0] == 5'd0);
        end
    end

    always_comb begin
        w_rgb = BLACK;
        if (r_active) begin
            if (r_sprite_hit)      w_rgb = SPRITE_COLOR;
            else if (r_border_hit) w_rgb = BORDER_COLOR;
            else if (r_grid_hit)   w_rgb = GRID;
            else                   w_rgb = BG_COLOR;
        end
    end
`else
    always_comb begin
        w_rgb = BLACK;
        if (r_active) begin
            if (r_sprite_hit)      w_rgb = SPRITE_COLOR;
            else if (r_border_hit) w_rgb = BORDER_COLOR;
            else                   w_rgb = BG_COLOR;
        end
    end
`endif

    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            r_rgb       <= BLACK;
            r_rgb_valid <= 1'b0;
        end else begin
            r_rgb       <= w_rgb;
            r_rgb_valid <= r_active;
        end
    end

    assign o_RGB       = r_rgb;
    assign o_RGB_VALID = r_rgb_valid;

endmodule

`default_nettype wire
